// File: rtl/obi_mem_responder.sv
// OBI memory responder: word-addressed byte-writable storage with a fixed-latency
// response pipeline and a cap on granted-but-unanswered transactions.
package obi_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module obi_mem_responder
    import obi_pkg::*;
#(
    parameter int NUM_WORDS       = 1024,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  req_i,
    output obi_resp_t resp_o,
    input  logic      stall_i
);

    localparam int AW = $clog2(NUM_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [31:0]    mem [NUM_WORDS];
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [31:0]    dat_q [LATENCY];
    logic [31:0]    dat_d [LATENCY];
    logic           gnt;
    logic           rvalid;
    logic [AW-1:0]  idx;
    logic           unused_addr;

    // Only the word-index bits select storage; everything else aliases.
    assign idx         = req_i.addr[AW+1:2];
    assign unused_addr = ^{req_i.addr[31:AW+2], req_i.addr[1:0]};
    assign rvalid      = vld_q[LATENCY-1];

    always_comb begin
        // A retiring response frees a slot in the same cycle, so a full counter may still grant.
        gnt   = req_i.req && !stall_i && !rst_i && ((cnt_q < CNT_MAX) || rvalid);
        cnt_d = cnt_q;
        if (gnt && !rvalid) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!gnt && rvalid) begin
            cnt_d = cnt_q - 1'b1;
        end

        vld_d    = '0;
        vld_d[0] = gnt;
        dat_d[0] = (gnt && !req_i.we) ? mem[idx] : 32'h0;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= 32'h0;
            end
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // Storage is deliberately not reset so contents survive a mid-flight reset.
    always_ff @(posedge clk_i) begin
        if (gnt && req_i.we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_i.be[b]) begin
                    mem[idx][8*b +: 8] <= req_i.wdata[8*b +: 8];
                end
            end
        end
    end

    assign resp_o.gnt    = gnt;
    assign resp_o.rvalid = rvalid;
    assign resp_o.rdata  = dat_q[LATENCY-1];

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: three configurations share one stimulus stream and are
// checked against a transaction-level model (timestamped response queue + byte memory).
module tb_obi_mem_responder;
    import obi_pkg::*;

    localparam int NI = 3;
    localparam int LAT_P [NI] = '{1, 4, 3};
    localparam int MAX_P [NI] = '{2, 2, 1};
    localparam int NW_P  [NI] = '{1024, 16, 1024};

    logic      clk = 1'b0;
    logic      rst;
    logic      stall;
    obi_req_t  req;
    obi_resp_t resp [NI];

    always #5 clk = ~clk;

    obi_mem_responder #(.NUM_WORDS(1024), .LATENCY(1), .MAX_OUTSTANDING(2)) u0 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .resp_o(resp[0]), .stall_i(stall));
    obi_mem_responder #(.NUM_WORDS(16), .LATENCY(4), .MAX_OUTSTANDING(2)) u1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .resp_o(resp[1]), .stall_i(stall));
    obi_mem_responder #(.NUM_WORDS(1024), .LATENCY(3), .MAX_OUTSTANDING(1)) u2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .resp_o(resp[2]), .stall_i(stall));

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [31:0] mask;
    } exp_t;

    exp_t        fifo [NI][16];
    int          head [NI];
    int          tail [NI];
    bit   [31:0] mem_m   [NI][1024];
    bit   [3:0]  known_m [NI][1024];
    logic [31:0] last_rd [NI];
    logic        g_s [NI];
    logic        v_s [NI];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got %h want %h", name, k, $time, got, want);
        end
    endtask

    // Scoreboard: push expected responses at grant, pop and compare when due.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            int   busy;
            int   idx;
            bit   rv_e;
            bit   g_e;
            exp_t e;
            busy = tail[k] - head[k];
            rv_e = !rst && (busy > 0) && (fifo[k][head[k] % 16].due == cyc);
            g_e  = !rst && req.req && !stall && ((busy < MAX_P[k]) || rv_e);
            chk("gnt", k, 32'(resp[k].gnt), 32'(g_e));
            chk("rvalid", k, 32'(resp[k].rvalid), 32'(rv_e));
            if (rv_e) begin
                e = fifo[k][head[k] % 16];
                chk("rdata", k, resp[k].rdata & e.mask, e.data & e.mask);
                last_rd[k] = resp[k].rdata;
                head[k]++;
            end else begin
                chk("rdata_idle", k, resp[k].rdata, 32'h0);
            end
            if (rst) begin
                head[k] = tail[k];
            end else if (g_e) begin
                idx    = int'(req.addr >> 2) % NW_P[k];
                e.data = 32'h0;
                e.mask = 32'h0;
                if (req.we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req.be[b]) begin
                            mem_m[k][idx][8*b +: 8] = req.wdata[8*b +: 8];
                            known_m[k][idx][b]      = 1'b1;
                        end
                    end
                    e.mask = 32'hFFFF_FFFF;
                end else begin
                    e.data = mem_m[k][idx];
                    for (int b = 0; b < 4; b++) begin
                        e.mask[8*b +: 8] = {8{known_m[k][idx][b]}};
                    end
                end
                e.due = cyc + LAT_P[k];
                fifo[k][tail[k] % 16] = e;
                tail[k]++;
            end
        end
        cyc++;
    end

    task automatic drive(input bit r, input bit we, input bit [3:0] be, input bit [31:0] addr,
                         input bit [31:0] wd, input bit st, input bit rs);
        req.req   = r;
        req.we    = we;
        req.be    = be;
        req.addr  = addr;
        req.wdata = wd;
        stall     = st;
        rst       = rs;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            g_s[k] = resp[k].gnt;
            v_s[k] = resp[k].rvalid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wr(input bit [31:0] addr, input bit [31:0] wd, input bit [3:0] be, input int n);
        repeat (n) drive(1'b1, 1'b1, be, addr, wd, 1'b0, 1'b0);
    endtask

    task automatic rd(input bit [31:0] addr, input int n);
        repeat (n) drive(1'b1, 1'b0, 4'hF, addr, 32'h0, 1'b0, 1'b0);
    endtask

    function automatic bit [31:0] raddr();
        return (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        bit [7:0] h0, h1, h2;
        bit       g_a, g_b, v_a, v_b, v_c;
        logic [31:0] d_c;
        int       n_rv;

        rst   = 1'b1;
        stall = 1'b0;
        req   = '0;
        repeat (3) drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b1);
        idle(2);

        // Back-to-back write then read of the same word on the latency-1 instance.
        wr(32'h10, 32'hDEADBEEF, 4'hF, 1);
        g_a = g_s[0]; v_a = v_s[0];
        rd(32'h10, 1);
        g_b = g_s[0]; v_b = v_s[0];
        idle(1);
        v_c = v_s[0]; d_c = last_rd[0];
        chk("b2b_gnt_wr", 0, 32'(g_a), 32'd1);
        chk("b2b_gnt_rd", 0, 32'(g_b), 32'd1);
        chk("b2b_rv_c0", 0, 32'(v_a), 32'd0);
        chk("b2b_rv_c1", 0, 32'(v_b), 32'd1);
        chk("b2b_rv_c2", 0, 32'(v_c), 32'd1);
        chk("b2b_rdata", 0, d_c, 32'hDEADBEEF);
        idle(8);

        // Byte enables, including an all-zero enable that must change nothing.
        wr(32'h20, 32'h11223344, 4'hF, 6);
        wr(32'h20, 32'hAABBCCDD, 4'b0101, 6);
        rd(32'h20, 6);
        idle(8);
        for (int k = 0; k < NI; k++) chk("be_merge", k, last_rd[k], 32'h11BB33DD);
        wr(32'h20, 32'hFFFFFFFF, 4'b0000, 6);
        rd(32'h20, 6);
        idle(8);
        for (int k = 0; k < NI; k++) chk("be_zero", k, last_rd[k], 32'h11BB33DD);

        // Throughput and outstanding cap from idle with req held 8 cycles.
        idle(10);
        for (int i = 0; i < 8; i++) begin
            rd(32'h40, 1);
            h0[i] = g_s[0]; h1[i] = g_s[1]; h2[i] = g_s[2];
        end
        chk("thru_lat1", 0, 32'(h0), 32'h000000FF);
        chk("cap_lat4", 1, 32'(h1), 32'h00000033);
        chk("cap_lat3", 2, 32'(h2), 32'h00000049);

        // Stall suppresses grants; address 0x1000 aliases word 0.
        idle(10);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b1, 1'b0);
            for (int k = 0; k < NI; k++) begin
                chk("stall_gnt", k, 32'(g_s[k]), 32'd0);
                chk("stall_rv", k, 32'(v_s[k]), 32'd0);
            end
        end
        wr(32'h1000, 32'h5A5A5A5A, 4'hF, 6);
        rd(32'h0, 6);
        idle(8);
        for (int k = 0; k < NI; k++) chk("wrap", k, last_rd[k], 32'h5A5A5A5A);

        // Reset while a read is in flight: its response must never appear.
        wr(32'h30, 32'h0BADF00D, 4'hF, 6);
        idle(8);
        rd(32'h30, 1);
        chk("rst_pre_gnt", 2, 32'(g_s[2]), 32'd1);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        n_rv = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            for (int k = 0; k < NI; k++) n_rv += int'(v_s[k]);
        end
        chk("rst_discard", 2, 32'(n_rv), 32'd0);
        rd(32'h30, 6);
        idle(8);
        for (int k = 0; k < NI; k++) chk("rst_retain", k, last_rd[k], 32'h0BADF00D);

        // Randomised traffic with stalls and occasional resets.
        repeat (700) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                  raddr(), $urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 100) == 0);
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 1024, meaning word-addressed storage depth, power of two, at least 2.
REQ-002 SHALL have parameter LATENCY, default 1, meaning cycles from grant to rvalid, range 1..4.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the cap on granted transactions still awaiting rvalid, at least 1.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port req_i, input, obi_req_t (req, we, be[3:0], addr[31:0], wdata[31:0]): the OBI request from the initiator.
REQ-007 SHALL have port resp_o, output, obi_resp_t (gnt, rvalid, rdata[31:0]): the OBI response to the initiator.
REQ-008 SHALL have port stall_i, input, 1 bit; when high it forces gnt low (wait-state injection).

Function
REQ-009 SHALL compute gnt combinationally as: req_i.req AND NOT stall_i AND (cnt < MAX_OUTSTANDING OR resp_o.rvalid).
REQ-010 SHALL keep outstanding counter cnt, width $clog2(MAX_OUTSTANDING+1); per cycle cnt_next = cnt + gnt - rvalid; it never exceeds MAX_OUTSTANDING and never underflows.
REQ-011 SHALL form the word index as addr[$clog2(NUM_WORDS)+1:2]; addr[1:0] and upper bits are ignored, so out-of-range addresses wrap modulo NUM_WORDS.
REQ-012 SHALL, on a granted write (we=1), update only the bytes whose be bit is set, at the clock edge ending the grant cycle; be=0000 changes no storage.
REQ-013 SHALL, on a granted read (we=0), sample the addressed word at the grant edge; a read granted in the cycle after a write to the same word returns the written data.
REQ-014 SHALL push each granted transaction into a LATENCY-deep shift pipeline (valid bit plus data) that advances every cycle unconditionally; there is no rready, so it never stalls.
REQ-015 SHALL drive resp_o.rvalid and resp_o.rdata from the final pipeline stage; rvalid is asserted exactly LATENCY cycles after the grant cycle, never in the grant cycle itself.
REQ-016 SHALL return rdata = 32'h0 with the rvalid of a write, and rdata = 32'h0 whenever rvalid is low.
REQ-017 SHALL deliver responses strictly in grant order, one rvalid per grant, with no lost or duplicated responses.
REQ-018 SHALL, in a cycle where rvalid retires one entry and a new grant occurs, leave cnt unchanged; a grant while cnt = MAX_OUTSTANDING is permitted only in that case.
REQ-019 SHALL sustain one grant per cycle when MAX_OUTSTANDING >= LATENCY; otherwise throughput is limited to MAX_OUTSTANDING per LATENCY cycles.
REQ-020 SHALL hold gnt low while req_i.req is low, regardless of stall_i or cnt.

Reset
REQ-021 SHALL, while rst_i is high, drive gnt=0, rvalid=0 and rdata=0, clear cnt and every pipeline valid bit; storage contents are not reset.
REQ-022 SHALL, if rst_i asserts mid-transaction, discard in-flight responses so no rvalid appears for them after release; storage written before reset is retained.
REQ-023 SHALL, in the first cycle after rst_i deasserts, evaluate gnt normally per REQ-009 with cnt = 0.

Verification
REQ-024 Back-to-back: LATENCY=1, MAX_OUTSTANDING=2; write 0xDEADBEEF to addr 0x10 (be=1111) then read 0x10 next cycle -> gnt both cycles; rvalid at cycles 1 and 2; second rdata = 0xDEADBEEF.
REQ-025 Byte enables: word at 0x20 = 0x11223344; write 0xAABBCCDD with be=0101 then read -> rdata = 0x11BB33DD.
REQ-026 Outstanding cap: LATENCY=4, MAX_OUTSTANDING=2, req held high 8 cycles -> gnt in cycles 0 and 1, low in cycles 2-3, high again in cycle 4 (rvalid retiring); cnt never exceeds 2.
REQ-027 Stall and wrap: NUM_WORDS=1024; stall_i high 3 cycles with req high -> no gnt and no rvalid; then write 0x5A5A5A5A to addr 0x1000 and read addr 0x0 -> rdata = 0x5A5A5A5A.
REQ-028 Reset mid-flight: LATENCY=3; grant a read, assert rst_i one cycle later for 2 cycles -> no rvalid ever appears for that read; cnt=0 after release; earlier writes still readable.
